// File: rtl/jx2_ex_cmp_srupd.sv
// jx2_ex_cmp_srupd: two-stage compare-to-SR update.
// Stage 1 captures the compare op and the upstream flags.
// Stage 2 selects the flag for the op, applies the invert bit and writes SR.T / SR.ST.
// A direct SR write (srWrEn) may land on the same edge; the compare owns the bits it writes.
// Optional feature macro: JX2_CMP_SIMD_EN enables packed-word / packed-long compares.
// Without the macro every packed compare retires as illegal.
module jx2_ex_cmp_srupd (
    input  logic       clock,
    input  logic       reset,
    input  logic       exHold,
    input  logic       exFlush,
    input  logic       opValid,
    input  logic [4:0] opCmd,
    input  logic       cmpEqL,
    input  logic       cmpEqQ,
    input  logic       cmpHiL,
    input  logic       cmpHiQ,
    input  logic       cmpHsL,
    input  logic       cmpHsQ,
    input  logic       tstL,
    input  logic       tstQ,
    input  logic [3:0] cmpEqPW,
    input  logic [3:0] cmpHiPW,
    input  logic [3:0] cmpHsPW,
    input  logic [1:0] cmpEqPL,
    input  logic [1:0] cmpHiPL,
    input  logic [1:0] cmpHsPL,
    input  logic       srWrEn,
    input  logic [4:0] srWrVal,
    output logic       srT,
    output logic [3:0] srST,
    output logic       resValid,
    output logic       opIllegal
);

    localparam logic [1:0] KIND_EQ  = 2'b00;
    localparam logic [1:0] KIND_HI  = 2'b01;
    localparam logic [1:0] KIND_HS  = 2'b10;
    localparam logic [1:0] KIND_TST = 2'b11;
    localparam logic [1:0] SIZE_PW  = 2'b10;

    // Stage-1 state. Scalar flags are packed so that {kind, size[0]} indexes them directly.
    logic        s1_valid_q, s1_valid_d;
    logic [4:0]  s1_cmd_q,   s1_cmd_d;
    logic [7:0]  s1_scal_q,  s1_scal_d;
    logic [11:0] s1_pw_q,    s1_pw_d;
    logic [5:0]  s1_pl_q,    s1_pl_d;

    // SR and retire pulses.
    logic        sr_t_q,       sr_t_d;
    logic [3:0]  sr_st_q,      sr_st_d;
    logic        res_valid_q,  res_valid_d;
    logic        op_illegal_q, op_illegal_d;

    // Decoded stage-1 op.
    logic        inv_s;
    logic [1:0]  kind_s;
    logic [1:0]  size_s;
    logic        scal_flag_s;
    logic [3:0]  pw_vec_s;
    logic [1:0]  pl_vec_s;
    logic [3:0]  packed_st_s;
    logic        illegal_s;
    logic [4:0]  sr_base_s;

    // Stage-1 capture: load a new op unless stalled; a flush kills only this stage.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cmd_d   = s1_cmd_q;
        s1_scal_d  = s1_scal_q;
        s1_pw_d    = s1_pw_q;
        s1_pl_d    = s1_pl_q;
        if (!exHold) begin
            s1_valid_d = opValid & ~exFlush;
            s1_cmd_d   = opCmd;
            s1_scal_d  = {tstQ, tstL, cmpHsQ, cmpHsL, cmpHiQ, cmpHiL, cmpEqQ, cmpEqL};
            s1_pw_d    = {cmpHsPW, cmpHiPW, cmpEqPW};
            s1_pl_d    = {cmpHsPL, cmpHiPL, cmpEqPL};
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-2 evaluation: pick the flag/vector for kind and size and decide legality.
    always_comb begin
        inv_s       = s1_cmd_q[4];
        kind_s      = s1_cmd_q[3:2];
        size_s      = s1_cmd_q[1:0];
        scal_flag_s = s1_scal_q[{kind_s, size_s[0]}];
        case (kind_s)
            KIND_EQ: begin pw_vec_s = s1_pw_q[3:0];  pl_vec_s = s1_pl_q[1:0]; end
            KIND_HI: begin pw_vec_s = s1_pw_q[7:4];  pl_vec_s = s1_pl_q[3:2]; end
            KIND_HS: begin pw_vec_s = s1_pw_q[11:8]; pl_vec_s = s1_pl_q[5:4]; end
            default: begin pw_vec_s = 4'b0000;       pl_vec_s = 2'b00;        end
        endcase
        if (size_s == SIZE_PW) begin
            packed_st_s = pw_vec_s ^ {4{inv_s}};
        end else begin
            packed_st_s = {pl_vec_s[1], pl_vec_s[1], pl_vec_s[0], pl_vec_s[0]} ^ {4{inv_s}};
        end
`ifdef JX2_CMP_SIMD_EN
        illegal_s = size_s[1] & (kind_s == KIND_TST);
`else
        illegal_s = size_s[1];
`endif
    end

    // SR update and retire pulses; everything holds while stalled.
    always_comb begin
        sr_t_d       = sr_t_q;
        sr_st_d      = sr_st_q;
        res_valid_d  = res_valid_q;
        op_illegal_d = op_illegal_q;
        sr_base_s    = srWrEn ? srWrVal : {sr_t_q, sr_st_q};
        if (!exHold) begin
            res_valid_d  = s1_valid_q & ~illegal_s;
            op_illegal_d = s1_valid_q &  illegal_s;
            sr_t_d       = sr_base_s[4];
            sr_st_d      = sr_base_s[3:0];
            if (s1_valid_q && !illegal_s) begin
                if (size_s[1]) begin
                    sr_st_d = packed_st_s;
                    sr_t_d  = &packed_st_s;
                end else begin
                    sr_t_d  = scal_flag_s ^ inv_s;
                end
            end else begin
                sr_t_d = sr_base_s[4];
            end
        end else begin
            sr_t_d = sr_t_q;
        end
    end

    // State registers with synchronous reset that overrides stall, flush and SR writes.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_cmd_q     <= 5'b00000;
            s1_scal_q    <= 8'h00;
            s1_pw_q      <= 12'h000;
            s1_pl_q      <= 6'b000000;
            sr_t_q       <= 1'b0;
            sr_st_q      <= 4'b0000;
            res_valid_q  <= 1'b0;
            op_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_cmd_q     <= s1_cmd_d;
            s1_scal_q    <= s1_scal_d;
            s1_pw_q      <= s1_pw_d;
            s1_pl_q      <= s1_pl_d;
            sr_t_q       <= sr_t_d;
            sr_st_q      <= sr_st_d;
            res_valid_q  <= res_valid_d;
            op_illegal_q <= op_illegal_d;
        end
    end

    assign srT       = sr_t_q;
    assign srST      = sr_st_q;
    assign resValid  = res_valid_q;
    assign opIllegal = op_illegal_q;

endmodule

// File: tb/tb_jx2_ex_cmp_srupd.sv
// Directed bench for jx2_ex_cmp_srupd. Observed value is {srT, srST, resValid, opIllegal}.
module tb_jx2_ex_cmp_srupd;

    logic       clock = 1'b0;
    logic       reset, exHold, exFlush, opValid;
    logic [4:0] opCmd;
    logic       cmpEqL, cmpEqQ, cmpHiL, cmpHiQ, cmpHsL, cmpHsQ, tstL, tstQ;
    logic [3:0] cmpEqPW, cmpHiPW, cmpHsPW;
    logic [1:0] cmpEqPL, cmpHiPL, cmpHsPL;
    logic       srWrEn;
    logic [4:0] srWrVal;
    logic       srT;
    logic [3:0] srST;
    logic       resValid, opIllegal;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic       exp_t;
    logic [3:0] exp_st;
    logic [6:0] exp_v;

    jx2_ex_cmp_srupd dut (
        .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush),
        .opValid(opValid), .opCmd(opCmd),
        .cmpEqL(cmpEqL), .cmpEqQ(cmpEqQ), .cmpHiL(cmpHiL), .cmpHiQ(cmpHiQ),
        .cmpHsL(cmpHsL), .cmpHsQ(cmpHsQ), .tstL(tstL), .tstQ(tstQ),
        .cmpEqPW(cmpEqPW), .cmpHiPW(cmpHiPW), .cmpHsPW(cmpHsPW),
        .cmpEqPL(cmpEqPL), .cmpHiPL(cmpHiPL), .cmpHsPL(cmpHsPL),
        .srWrEn(srWrEn), .srWrVal(srWrVal),
        .srT(srT), .srST(srST), .resValid(resValid), .opIllegal(opIllegal)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        opValid = 1'b0; exFlush = 1'b0; exHold = 1'b0; srWrEn = 1'b0;
        srWrVal = 5'b00000; opCmd = 5'b00000;
        cmpEqL = 1'b0; cmpEqQ = 1'b0; cmpHiL = 1'b0; cmpHiQ = 1'b0;
        cmpHsL = 1'b0; cmpHsQ = 1'b0; tstL = 1'b0; tstQ = 1'b0;
        cmpEqPW = 4'b0000; cmpHiPW = 4'b0000; cmpHsPW = 4'b0000;
        cmpEqPL = 2'b00; cmpHiPL = 2'b00; cmpHsPL = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        exp_t = 1'b0; exp_st = 4'b0000;
        exp_v = 7'b0000000;
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_state: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_idle: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_eq_l();
        opValid = 1'b1; opCmd = 5'b0_00_00; cmpEqL = 1'b1;
        step();
        idle();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL eq_l_latency: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_t = 1'b1;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL eq_l_retire: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL eq_l_pulse_end: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_pw();
        opValid = 1'b1; opCmd = 5'b1_00_10; cmpEqPW = 4'b0101;
        step();
        idle();
        step();
`ifdef JX2_CMP_SIMD_EN
        exp_st = 4'b1010; exp_t = 1'b0;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
`else
        exp_v = {exp_t, exp_st, 1'b0, 1'b1};
`endif
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL eq_pw_inv: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL eq_pw_pulse_end: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_pl();
        opValid = 1'b1; opCmd = 5'b0_10_11; cmpHsPL = 2'b10;
        step();
        cmpHsPL = 2'b11;
        step();
        idle();
`ifdef JX2_CMP_SIMD_EN
        exp_st = 4'b1100; exp_t = 1'b0;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
`else
        exp_v = {exp_t, exp_st, 1'b0, 1'b1};
`endif
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL hs_pl_first: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
`ifdef JX2_CMP_SIMD_EN
        exp_st = 4'b1111; exp_t = 1'b1;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
`else
        exp_v = {exp_t, exp_st, 1'b0, 1'b1};
`endif
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL hs_pl_second: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL hs_pl_pulse_end: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_hold();
        srWrEn = 1'b1; srWrVal = 5'b0_0011;
        step();
        idle();
        exp_t = 1'b0; exp_st = 4'b0011;
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL sr_direct_write: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        opValid = 1'b1; opCmd = 5'b0_01_01; cmpHiQ = 1'b1;
        step();
        exHold = 1'b1; cmpHiQ = 1'b0; opCmd = 5'b0_00_00; cmpEqL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if ({srT, srST, resValid, opIllegal} !== exp_v) begin
                tests_failed++;
                $display("FAIL hold_frozen[%0d]: got %b want %b", i, {srT, srST, resValid, opIllegal}, exp_v);
            end
        end
        idle();
        step();
        exp_t = 1'b1;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_release: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_single_pulse: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_flush();
        opValid = 1'b1; exFlush = 1'b1; opCmd = 5'b1_11_00; tstL = 1'b1;
        step();
        idle();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            step();
            tests_run++;
            if ({srT, srST, resValid, opIllegal} !== exp_v) begin
                tests_failed++;
                $display("FAIL flush_killed[%0d]: got %b want %b", i, {srT, srST, resValid, opIllegal}, exp_v);
            end
        end
        opValid = 1'b1; opCmd = 5'b0_11_11;
        step();
        idle();
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b1};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL tst_pl_illegal: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL tst_pl_pulse_end: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        // Op already in stage 2 retires even though a flush arrives behind it.
        opValid = 1'b1; opCmd = 5'b1_01_00; cmpHiL = 1'b1;
        step();
        opCmd = 5'b0_00_00; cmpEqL = 1'b1; exFlush = 1'b1;
        step();
        idle();
        exp_t = 1'b0;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL flush_s2_retires: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL flush_s1_dropped: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_wr_merge();
        opValid = 1'b1; opCmd = 5'b0_01_00; cmpHiL = 1'b0;
        step();
        idle();
        srWrEn = 1'b1; srWrVal = 5'b1_0110;
        step();
        idle();
        exp_t = 1'b0; exp_st = 4'b0110;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL wr_merge: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        opValid = 1'b1; opCmd = 5'b0_00_00; cmpEqL = 1'b1;
        step();
        opCmd = 5'b0_10_01; cmpEqL = 1'b0; cmpHsQ = 1'b0;
        step();
        exp_t = 1'b1;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_op1: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        opCmd = 5'b1_11_01; tstQ = 1'b0;
        step();
        idle();
        exp_t = 1'b0;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_op2: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_t = 1'b1;
        exp_v = {exp_t, exp_st, 1'b1, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_op3: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        step();
        exp_v = {exp_t, exp_st, 1'b0, 1'b0};
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_drain: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    task automatic test_reset_midflight();
        opValid = 1'b1; opCmd = 5'b1_00_00; cmpEqL = 1'b0;
        step();
        idle();
        reset = 1'b1; exHold = 1'b1; srWrEn = 1'b1; srWrVal = 5'b1_1111;
        step();
        exp_t = 1'b0; exp_st = 4'b0000;
        exp_v = 7'b0000000;
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_priority: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
        reset = 1'b0;
        idle();
        step();
        tests_run++;
        if ({srT, srST, resValid, opIllegal} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_discard: got %b want %b", {srT, srST, resValid, opIllegal}, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_eq_l();
        test_pw();
        test_pl();
        test_hold();
        test_flush();
        test_wr_merge();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/jx2_ex_cmp_srupd.md
JX2_EX_CMP_SRUPD -- requirements
Module: jx2_ex_cmp_srupd

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- exHold  in  1  pipeline stall; freezes all state.
- exFlush  in  1  kills the op in stage 1.
- opValid  in  1  compare op present this cycle.
- opCmd  in  5  [4]=invert; [3:2] kind 00 EQ, 01 HI, 10 HS, 11 TST; [1:0] size 00 L, 01 Q, 10 PW, 11 PL.
- cmpEqL, cmpEqQ, cmpHiL, cmpHiQ, cmpHsL, cmpHsQ, tstL, tstQ  in  1 each  scalar flags from the upstream compare unit.
- cmpEqPW, cmpHiPW, cmpHsPW  in  4 each  packed-word flags.
- cmpEqPL, cmpHiPL, cmpHsPL  in  2 each  packed-long flags.
- srWrEn  in  1  direct SR predicate write.
- srWrVal  in  5  {T, ST[3:0]} to write.
- srT  out  1  SR T bit.
- srST  out  4  SR packed predicate bits.
- resValid  out  1  one-cycle pulse: SR updated by a compare.
- opIllegal  out  1  one-cycle pulse: illegal compare retired.
REQ-002 SHALL use one clock; reset is synchronous and active-high.

Function
REQ-003 Stage 1 SHALL capture opValid, opCmd and every flag input on a clock edge with exHold=0; stage-1 valid SHALL be opValid & ~exFlush.
REQ-004 Stage 2 SHALL evaluate the captured op and update srT/srST on the next edge with exHold=0; latency SHALL be 2 edges from capture to visible SR, resValid asserted in the cycle the new SR is visible.
REQ-005 Flag selection: kind/size SHALL select the matching upstream flag (e.g. HI,Q -> cmpHiQ; EQ,PW -> cmpEqPW).
REQ-006 Size L or Q: srT SHALL be flag ^ invert; srST SHALL be unchanged.
REQ-007 Size PW: srST SHALL be vector ^ {4{invert}}; srT SHALL be the AND of the new srST.
REQ-008 Size PL: srST SHALL be {PL[1],PL[1],PL[0],PL[0]} ^ {4{invert}}; srT SHALL be the AND of the new srST.
REQ-009 TST with size PW or PL SHALL be illegal: SR unchanged, opIllegal pulsed in place of resValid.
REQ-010 exHold=1 SHALL freeze both stages, SR and outputs; resValid/opIllegal SHALL NOT re-pulse on release.
REQ-011 exFlush SHALL affect stage 1 only; an op already in stage 2 SHALL retire.
REQ-012 srWrEn (sampled when exHold=0) SHALL load srWrVal into {srT, srST} on that edge; if a compare retires on the same edge, the compare result SHALL win for the bits it writes, and srWrVal SHALL supply the remaining bits.
REQ-013 Back-to-back ops SHALL retire one per cycle, with no bubbles when exHold=0.

Reset
REQ-014 On reset: srT=0, srST=0000, resValid=0, opIllegal=0, both stage valids 0.
REQ-015 Reset SHALL win over exHold, exFlush and srWrEn; ops in flight SHALL be discarded without pulses.

Configuration
REQ-016 Macro JX2_CMP_SIMD_EN: when defined, PW/PL ops behave per REQ-007/008; when undefined, every PW/PL op SHALL be illegal per REQ-009, and the packed flag inputs SHALL remain as ports but be unused.

Verification
REQ-017 Reset, then EQ,L with cmpEqL=1 at cycle 0 -> srT=1, resValid=1 after edge 2; srST=0000.
REQ-018 EQ,PW, invert=1, cmpEqPW=0101 -> srST=1010, srT=0; with macro undefined -> opIllegal=1, SR unchanged.
REQ-019 HS,PL, cmpHsPL=10 -> srST=1100, srT=0; then HS,PL, cmpHsPL=11 next cycle -> srST=1111, srT=1 one cycle later.
REQ-020 HI,Q op, exHold=1 for 3 cycles after capture -> SR and resValid frozen; on release, a single resValid pulse with the correct srT.
REQ-021 TST,L captured with exFlush=1 -> no SR change, no pulses; TST,PL -> opIllegal pulse.
REQ-022 srWrEn with srWrVal=1_0110 on the same edge a HI,L op retires with cmpHiL=0 -> srT=0, srST=0110.
